pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Produces the stall and flush controls for the PC, IF/ID and ID/EX stage registers. Its `idExFlush` drives the `flush` input of the EX stage register.
- Detects load-use and RAW hazards and redirects on EX-resolved branches.
- Tracks a multi-cycle mult/div unit (MDU) busy window and stalls dependent instructions.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stall/flush controls,
// MDU busy window, saturating stall counter. Define PIPELINE_FORWARDING_EN when EX/MEM->EX forwarding exists.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idMduOp,
  input  logic             idMduRead,
  input  logic [4:0]       exDest,
  input  logic             exRegWrite,
  input  logic             exMemRead,
  input  logic [4:0]       memDest,
  input  logic             memRegWrite,
  input  logic             exBranchTaken,
  output logic             pcStall,
  output logic             ifIdStall,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             mduBusy,
  output logic [CNT_W-1:0] mduCount,
  output logic [31:0]      stallCount
);

  localparam logic [CNT_W-1:0] MduLoad  = CNT_W'(MDU_LATENCY);
  localparam logic [31:0]      StallMax = 32'hFFFF_FFFF;

  // $0 is hardwired to zero, so it can never carry a dependency
  function automatic logic reg_hit(input logic [4:0] dest, input logic wr,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rs, input logic use_rt);
    reg_hit = wr && (dest != 5'd0) && ((use_rs && (rs == dest)) || (use_rt && (rt == dest)));
  endfunction

  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             hit_ex, load_use, mdu_haz, data_haz, stall;

`ifdef PIPELINE_FORWARDING_EN
  logic unused_mem;
  assign unused_mem = ^{memDest, memRegWrite};
`endif

  // Hazard detection and stall/flush priority
  always_comb begin
    hit_ex   = reg_hit(exDest, exRegWrite, idRs, idRt, idUsesRs, idUsesRt);
    load_use = hit_ex && exMemRead;
    mdu_haz  = (mdu_cnt_q != '0) && (idMduOp || idMduRead);
`ifdef PIPELINE_FORWARDING_EN
    data_haz = load_use;
`else
    data_haz = hit_ex || reg_hit(memDest, memRegWrite, idRs, idRt, idUsesRs, idUsesRt);
`endif
    stall     = (data_haz || mdu_haz) && !exBranchTaken;
    pcStall   = 1'b0;
    ifIdStall = 1'b0;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    if (exBranchTaken) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (stall) begin
      pcStall   = 1'b1;
      ifIdStall = 1'b1;
      idExFlush = 1'b1;
    end else begin
      pcStall   = 1'b0;
    end
  end

  // Next-state for the MDU busy window and the saturating stall counter
  always_comb begin
    mdu_cnt_d   = mdu_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (idMduOp && !stall && !exBranchTaken) begin
      mdu_cnt_d = MduLoad;
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mdu_cnt_d = '0;
    end
    if (pcStall && (stall_cnt_q != StallMax)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counters update on the falling edge, alongside the pipeline stage registers
  always_ff @(negedge clk) begin
    if (!resetN) begin
      mdu_cnt_q   <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mduBusy    = (mdu_cnt_q != '0);
  assign mduCount   = mdu_cnt_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus
// compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN;
  logic [4:0]    idRs, idRt, exDest, memDest;
  logic          idUsesRs, idUsesRt, idMduOp, idMduRead;
  logic          exRegWrite, exMemRead, memRegWrite, exBranchTaken;
  logic          pcStall, ifIdStall, ifIdFlush, idExFlush, mduBusy;
  logic [CW-1:0] mduCount;
  logic [31:0]   stallCount;

  pipeline_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .resetN(resetN), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idMduOp(idMduOp), .idMduRead(idMduRead),
    .exDest(exDest), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .memDest(memDest), .memRegWrite(memRegWrite), .exBranchTaken(exBranchTaken),
    .pcStall(pcStall), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
    .mduBusy(mduBusy), .mduCount(mduCount), .stallCount(stallCount)
  );

  int n_total = 0;
  int n_bad   = 0;

  // model state: remaining MDU cycles and cycles stalled so far
  int          m_mdu;
  longint      m_stalls;
  bit          m_stall;
  logic [31:0] e_pc, e_ifs, e_iff, e_idf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (idUsesRs && idRs == r) || (idUsesRt && idRt == r);
  endfunction

  task automatic predict();
    bit dh;
    bit mh;
`ifdef PIPELINE_FORWARDING_EN
    dh = exRegWrite && exMemRead && id_reads(exDest);
`else
    dh = (exRegWrite && id_reads(exDest)) || (memRegWrite && id_reads(memDest));
`endif
    mh = (m_mdu > 0) && (idMduOp || idMduRead);
    m_stall = (dh || mh) && !exBranchTaken;
    e_iff = {31'd0, exBranchTaken};
    e_idf = {31'd0, exBranchTaken || m_stall};
    e_pc  = {31'd0, m_stall};
    e_ifs = {31'd0, m_stall};
  endtask

  // check outputs mid-cycle, then advance the model across the falling edge
  task automatic cycle(input string tag);
    #1;
    predict();
    check_eq({tag, ".pcStall"},   {31'd0, pcStall},   e_pc);
    check_eq({tag, ".ifIdStall"}, {31'd0, ifIdStall}, e_ifs);
    check_eq({tag, ".ifIdFlush"}, {31'd0, ifIdFlush}, e_iff);
    check_eq({tag, ".idExFlush"}, {31'd0, idExFlush}, e_idf);
    check_eq({tag, ".mduCount"},  {29'd0, mduCount},  32'(m_mdu));
    check_eq({tag, ".mduBusy"},   {31'd0, mduBusy},   {31'd0, m_mdu > 0});
    check_eq({tag, ".stallCount"}, stallCount,        m_stalls[31:0]);
    @(negedge clk);
    if (!resetN) begin
      m_mdu    = 0;
      m_stalls = 0;
    end else begin
      if (idMduOp && !m_stall && !exBranchTaken) m_mdu = LAT;
      else if (m_mdu > 0) m_mdu = m_mdu - 1;
      if (m_stall && m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls = m_stalls + 1;
    end
    @(posedge clk);
  endtask

  task automatic clear_inputs();
    resetN = 1'b1; idRs = 5'd0; idRt = 5'd0; exDest = 5'd0; memDest = 5'd0;
    idUsesRs = 1'b0; idUsesRt = 1'b0; idMduOp = 1'b0; idMduRead = 1'b0;
    exRegWrite = 1'b0; exMemRead = 1'b0; memRegWrite = 1'b0; exBranchTaken = 1'b0;
  endtask

  task automatic set_load_use();
    clear_inputs();
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
  endtask

  initial begin
    clear_inputs();
    resetN = 1'b0;
    idMduOp = 1'b1;
    repeat (2) @(negedge clk);
    m_mdu = 0;
    m_stalls = 0;
    @(posedge clk);
    check_eq("rst.mduCount", {29'd0, mduCount}, 32'd0);
    check_eq("rst.stallCount", stallCount, 32'd0);
    cycle("rst");

    set_load_use();
    #1 check_eq("lu.pcStall_direct", {31'd0, pcStall}, 32'd1);
    cycle("lu");
    check_eq("lu.stallCount_direct", stallCount, 32'd1);
    exDest = 5'd0; idRs = 5'd0;
    cycle("lu_r0");
    check_eq("lu_r0.stallCount_direct", stallCount, 32'd1);

    set_load_use();
    exBranchTaken = 1'b1;
    #1 check_eq("br.ifIdFlush_direct", {31'd0, ifIdFlush}, 32'd1);
    check_eq("br.pcStall_direct", {31'd0, pcStall}, 32'd0);
    cycle("br");
    check_eq("br.stallCount_direct", stallCount, 32'd1);

    clear_inputs();
    idMduOp = 1'b1;
    cycle("mdu_issue");
    clear_inputs();
    idMduRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("mflo.count_direct", {29'd0, mduCount}, 32'(LAT - i));
      #1 check_eq("mflo.pcStall_direct", {31'd0, pcStall}, {31'd0, i < LAT});
      cycle("mflo");
    end

    clear_inputs();
    exRegWrite = 1'b1; exDest = 5'd9; idRt = 5'd9; idUsesRt = 1'b1;
`ifdef PIPELINE_FORWARDING_EN
    #1 check_eq("raw_ex.direct", {31'd0, pcStall}, 32'd0);
`else
    #1 check_eq("raw_ex.direct", {31'd0, pcStall}, 32'd1);
`endif
    cycle("raw_ex");
    exRegWrite = 1'b0; memRegWrite = 1'b1; memDest = 5'd9;
`ifdef PIPELINE_FORWARDING_EN
    #1 check_eq("raw_mem.direct", {31'd0, pcStall}, 32'd0);
`else
    #1 check_eq("raw_mem.direct", {31'd0, pcStall}, 32'd1);
`endif
    cycle("raw_mem");

    clear_inputs();
    idMduOp = 1'b1;
    cycle("rstmid_issue");
    clear_inputs();
    cycle("rstmid_busy");
    resetN = 1'b0;
    idMduRead = 1'b1;
    cycle("rstmid_assert");
    check_eq("rstmid.mduCount_direct", {29'd0, mduCount}, 32'd0);
    resetN = 1'b1;
    cycle("rstmid_after");

    set_load_use();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    m_stalls = 64'h0000_0000_FFFF_FFFD;
    for (int i = 0; i < 4; i++) cycle("sat");
    check_eq("sat.direct", stallCount, 32'hFFFF_FFFF);
    clear_inputs();
    resetN = 1'b0;
    cycle("sat_clr");

    for (int i = 0; i < 1500; i++) begin
      resetN        = ($urandom_range(0, 49) != 0);
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      exDest        = 5'($urandom_range(0, 3));
      memDest       = 5'($urandom_range(0, 3));
      idUsesRs      = 1'($urandom_range(0, 1));
      idUsesRt      = 1'($urandom_range(0, 1));
      exRegWrite    = 1'($urandom_range(0, 1));
      exMemRead     = 1'($urandom_range(0, 1));
      memRegWrite   = 1'($urandom_range(0, 1));
      exBranchTaken = ($urandom_range(0, 7) == 0);
      idMduOp       = ($urandom_range(0, 5) == 0);
      idMduRead     = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
